mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//   Sequences one dot product of vec_len operand pairs through an external
//   accumulating MAC datapath (DATA_W x DATA_W multiply, ACC_W accumulator).
//   Clears the accumulator, streams operands in, flushes the MAC pipeline and
//   returns the sum over a valid/ready result port. Sits between a neuron
//   layer controller (start/len) and one MAC instance.
// PARAMETERS
//   DATA_W   8                 operand width (unsigned)
//   ACC_W    2*DATA_W+1        accumulator/result width, matches MAC output
//   LEN_W    8                 width of vec_len; max terms = 2**LEN_W-1
//   MAC_LAT  2                 cycles from last enabled operand to mac_result valid
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high reset
//   start       in   1       begin a dot product; sampled only in IDLE
//   vec_len     in   LEN_W   number of operand pairs, latched when start accepted
//   busy        out  1       high in every state except IDLE
//   in_valid    in   1       operand pair present
//   in_ready    out  1       sequencer accepts operand pair
//   in_a        in   DATA_W  operand 1
//   in_b        in   DATA_W  operand 2
//   mac_clear   out  1       synchronous accumulator clear to MAC
//   mac_enable  out  1       MAC pipeline advance
//   mac_num_1   out  DATA_W  MAC operand 1
//   mac_num_2   out  DATA_W  MAC operand 2
//   mac_result  in   ACC_W   MAC accumulator output
//   res_valid   out  1       result available
//   res_ready   in   1       consumer accepts result
//   res_data    out  ACC_W   dot-product result
// BEHAVIOUR
//   Reset (async): state=IDLE; busy, in_ready, mac_clear, mac_enable, res_valid=0;
//     mac_num_1/2=0; res_data=0; term and drain counters=0. Reset mid-operation
//     abandons the current job; no result is produced.
//   FSM: IDLE -> CLEAR -> ACCUM -> DRAIN -> OUT -> IDLE.
//   IDLE : start=1 latches vec_len into remaining-term counter, -> CLEAR.
//   CLEAR: exactly one cycle; mac_clear=1, mac_enable=0.
//     vec_len=0 -> OUT with res_data=0 (ACCUM/DRAIN skipped); else -> ACCUM.
//   ACCUM: in_ready=1, mac_enable=1 every cycle. Operand pair accepted when
//     in_valid&in_ready: mac_num_1/2 = in_a/in_b (combinational pass-through),
//     counter decrements. in_valid=0: mac_num_1/2 = 0 (adds zero, pipeline flows).
//     On accepting the last pair -> DRAIN; in_ready=0 from the next cycle.
//   DRAIN: mac_enable=1, operands 0, for exactly MAC_LAT cycles; on the last
//     DRAIN cycle res_data <= mac_result, -> OUT.
//   OUT  : res_valid=1, res_data stable until res_valid&res_ready; -> IDLE
//     the same edge. res_valid drops the next cycle.
//   start while busy is ignored (not queued). Next start accepted earliest the
//     cycle after the OUT->IDLE transition.
//   mac_enable=0 and mac_clear=0 in IDLE and OUT; mac_clear never with enable.
//   Arithmetic: unsigned; sum wraps modulo 2**ACC_W (no saturation, no flag).
//   Latency (no stalls): start -> res_valid = 1+1+vec_len+MAC_LAT cycles.
// TESTING
//   1 vec_len=3, pairs (2,3),(4,5),(6,7) back-to-back -> res_data=68,
//     res_valid 7 cycles after start (MAC_LAT=2), exactly 3 in_ready handshakes.
//   2 Same job, in_valid low 2 cycles between each pair -> res_data=68,
//     counter unchanged during gaps, mac_num_1/2=0 on gap cycles.
//   3 vec_len=3, all pairs (255,255) -> res_data=195075 mod 2**17=64003.
//   4 vec_len=0 -> mac_clear pulse, res_data=0, res_valid 2 cycles after start,
//     mac_enable never asserted.
//   5 res_ready held low 5 cycles in OUT; start pulsed meanwhile -> res_valid/
//     res_data held, start ignored; after handshake, new start runs normally.
//   6 reset asserted mid-ACCUM (after 1 of 4 pairs) -> all outputs 0 immediately,
//     IDLE; following vec_len=1 job (9,9) -> res_data=81.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Runs one dot product of vec_len unsigned operand pairs through an external
//   accumulating MAC. The job proceeds in these steps:
//     1. Clear the MAC accumulator.
//     2. Stream operand pairs into the MAC.
//     3. Keep the MAC enabled for MAC_LAT cycles so its pipeline empties.
//     4. Hold the captured sum on a valid/ready result port.
//
// Ports
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   start, vec_len        job request (sampled in IDLE only) and pair count
//   busy                  high whenever a job is in progress
//   in_valid/in_ready     operand-pair handshake; in_a, in_b are the operands
//   mac_clear, mac_enable control for the external MAC
//   mac_num_1, mac_num_2  MAC operands (zero whenever no pair is accepted)
//   mac_result            MAC accumulator output
//   res_valid/res_ready   result handshake; res_data is the dot-product sum
module mac_dot_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 2*DATA_W+1,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              mac_clear,
    output logic              mac_enable,
    output logic [DATA_W-1:0] mac_num_1,
    output logic [DATA_W-1:0] mac_num_2,
    input  logic [ACC_W-1:0]  mac_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam int DCNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(MAC_LAT - 1);
    localparam logic [LEN_W-1:0]  ONE_TERM   = LEN_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   term_cnt;   // operand pairs still to accept
    logic [DCNT_W-1:0]  drain_cnt;  // cycles spent in DRAIN so far
    logic               accept;
    logic               drain_done;

    assign accept     = (state == S_ACCUM) && in_valid;
    assign drain_done = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);

    // Every output is decoded from the state register. An asynchronous reset
    // forces IDLE, so all outputs drop at once without waiting for a clock.
    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        in_ready   = 1'b0;
        mac_clear  = 1'b0;
        mac_enable = 1'b0;
        mac_num_1  = '0;
        mac_num_2  = '0;
        res_valid  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clear = 1'b1;
                // An empty job skips the MAC entirely and reports zero.
                state_nxt = (term_cnt == '0) ? S_OUT : S_ACCUM;
            end
            S_ACCUM: begin
                in_ready   = 1'b1;
                mac_enable = 1'b1;
                // Idle cycles feed zeros so the pipeline keeps flowing
                // without changing the sum.
                if (in_valid) begin
                    mac_num_1 = in_a;
                    mac_num_2 = in_b;
                    if (term_cnt == ONE_TERM) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                mac_enable = 1'b1;
                if (drain_done) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            term_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            term_cnt <= vec_len;
        end else if (accept) begin
            term_cnt <= term_cnt - ONE_TERM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (state == S_DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    // Zeroing the result in CLEAR gives an empty job its zero result. For a
    // non-empty job the value is overwritten when DRAIN finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_data <= '0;
        end else if (state == S_CLEAR) begin
            res_data <= '0;
        end else if (drain_done) begin
            res_data <= mac_result;
        end
    end

`ifndef SYNTHESIS
    a_clear_not_with_enable : assert property (
        @(posedge clk) disable iff (reset) !(mac_clear && mac_enable));

    a_result_held : assert property (
        @(posedge clk) disable iff (reset)
        (res_valid && !res_ready) |=> (res_valid && res_data == $past(res_data)));
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
module tb_mac_dot_sequencer;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 2*DATA_W+1;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  vec_len;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              mac_clear;
    logic              mac_enable;
    logic [DATA_W-1:0] mac_num_1;
    logic [DATA_W-1:0] mac_num_2;
    logic [ACC_W-1:0]  mac_result;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;

    int checks = 0;
    int errors = 0;

    mac_dot_sequencer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .vec_len(vec_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_clear(mac_clear), .mac_enable(mac_enable),
        .mac_num_1(mac_num_1), .mac_num_2(mac_num_2), .mac_result(mac_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // External MAC: product register, then accumulator (two-cycle latency).
    logic [ACC_W-1:0] m_prod = '0;
    logic [ACC_W-1:0] m_acc  = '0;
    always @(posedge clk) begin
        if (mac_clear) begin
            m_prod <= '0;
            m_acc  <= '0;
        end else if (mac_enable) begin
            m_prod <= ACC_W'(mac_num_1) * ACC_W'(mac_num_2);
            m_acc  <= m_acc + m_prod;
        end
    end
    assign mac_result = m_acc;

    // Operand table and reference model.
    logic [DATA_W-1:0] opa [0:63];
    logic [DATA_W-1:0] opb [0:63];

    function automatic logic [ACC_W-1:0] ref_sum(input int len);
        longint unsigned s = 0;
        for (int i = 0; i < len; i++) s += longint'(opa[i]) * longint'(opb[i]);
        return ACC_W'(s % (longint'(1) << ACC_W));
    endfunction

    function automatic int ref_latency(input int len, input int gap);
        if (len == 0) return 2;
        return 2 + len + gap*(len-1) + MAC_LAT;
    endfunction

    // Observations from the most recent run_job.
    logic [ACC_W-1:0] r_result;
    int r_lat, r_hs, r_rdy, r_clr, r_en;
    int r_pass_bad, r_zero_bad, r_hold_bad, r_drop_bad;
    bit r_timeout, r_busy_after, r_valid_after;

    // Drives one job: pairs from opa/opb, `gap` idle cycles after each
    // accepted pair, res_ready raised after res_valid has been seen
    // rdy_delay times, and optionally a stray start pulse during OUT.
    task automatic run_job(input int len, input int gap, input int rdy_delay,
                           input bit poke_start);
        int idx = 0, gap_left = 0, k = 0, wait_cnt = 0;
        bit got_valid = 0, done = 0;
        r_result = '0; r_lat = -1; r_hs = 0; r_rdy = 0; r_clr = 0; r_en = 0;
        r_pass_bad = 0; r_zero_bad = 0; r_hold_bad = 0; r_drop_bad = 0;
        @(negedge clk);
        start = 1'b1; vec_len = LEN_W'(len); in_valid = 1'b0; res_ready = 1'b0;
        while (!done && k < 500) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (idx < len && gap_left == 0) begin
                in_valid = 1'b1; in_a = opa[idx]; in_b = opb[idx];
            end else begin
                if (gap_left > 0) gap_left--;
                in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
            end
            res_ready = 1'b0;
            if (poke_start && got_valid && wait_cnt == 2) start = 1'b1;
            #1;
            if (mac_clear)  r_clr++;
            if (mac_enable) r_en++;
            if (in_ready)   r_rdy++;
            if (in_ready && in_valid) begin
                r_hs++;
                if (mac_num_1 !== in_a || mac_num_2 !== in_b) r_pass_bad++;
                idx++;
                gap_left = gap;
            end else if (mac_num_1 !== '0 || mac_num_2 !== '0) begin
                r_zero_bad++;
            end
            if (res_valid) begin
                if (!got_valid) begin
                    got_valid = 1; r_lat = k; r_result = res_data;
                end else if (res_data !== r_result) begin
                    r_hold_bad++;
                end
                if (wait_cnt >= rdy_delay) begin
                    res_ready = 1'b1; done = 1;
                end
                wait_cnt++;
            end else if (got_valid) begin
                r_drop_bad++;
            end
        end
        r_timeout = !done;
        @(negedge clk);
        res_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
        #1;
        r_busy_after  = busy;
        r_valid_after = res_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; vec_len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, in_ready, mac_clear, mac_enable, res_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {busy, in_ready, mac_clear, mac_enable, res_valid});
        end
        checks++;
        if (mac_num_1 !== '0 || mac_num_2 !== '0 || res_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %0d/%0d/%0d want 0/0/0",
                     mac_num_1, mac_num_2, res_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        opa[0] = 2; opb[0] = 3; opa[1] = 4; opb[1] = 5; opa[2] = 6; opb[2] = 7;
        run_job(3, 0, 0, 0);
        checks++;
        if (r_timeout || r_result !== 17'd68) begin
            errors++;
            $display("FAIL b2b_result got %0d want 68 (timeout %0d)", r_result, r_timeout);
        end
        checks++;
        if (r_lat !== 7) begin
            errors++; $display("FAIL b2b_latency got %0d want 7", r_lat);
        end
        checks++;
        if (r_hs !== 3 || r_rdy !== 3) begin
            errors++;
            $display("FAIL b2b_handshakes got %0d/%0d want 3/3", r_hs, r_rdy);
        end
        checks++;
        if (r_clr !== 1 || r_en !== 3 + MAC_LAT || r_pass_bad !== 0 || r_zero_bad !== 0) begin
            errors++;
            $display("FAIL b2b_mac_ctrl clr %0d en %0d pass %0d zero %0d want 1 5 0 0",
                     r_clr, r_en, r_pass_bad, r_zero_bad);
        end
        checks++;
        if (r_busy_after !== 1'b0 || r_valid_after !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle busy %0d valid %0d want 0 0", r_busy_after, r_valid_after);
        end
    endtask

    task automatic test_gaps();
        opa[0] = 2; opb[0] = 3; opa[1] = 4; opb[1] = 5; opa[2] = 6; opb[2] = 7;
        run_job(3, 2, 0, 0);
        checks++;
        if (r_timeout || r_result !== 17'd68) begin
            errors++; $display("FAIL gap_result got %0d want 68", r_result);
        end
        checks++;
        if (r_hs !== 3 || r_rdy !== 7 || r_lat !== 11) begin
            errors++;
            $display("FAIL gap_timing hs %0d ready %0d lat %0d want 3 7 11", r_hs, r_rdy, r_lat);
        end
        checks++;
        if (r_zero_bad !== 0 || r_pass_bad !== 0) begin
            errors++;
            $display("FAIL gap_operands zero %0d pass %0d want 0 0", r_zero_bad, r_pass_bad);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin opa[i] = 8'd255; opb[i] = 8'd255; end
        run_job(3, 0, 1, 0);
        checks++;
        if (r_timeout || r_result !== 17'd64003) begin
            errors++; $display("FAIL wrap_result got %0d want 64003", r_result);
        end
    endtask

    task automatic test_zero_len();
        run_job(0, 0, 0, 0);
        checks++;
        if (r_timeout || r_result !== '0 || r_lat !== 2) begin
            errors++;
            $display("FAIL zero_result got %0d lat %0d want 0 lat 2", r_result, r_lat);
        end
        checks++;
        if (r_clr !== 1 || r_en !== 0 || r_hs !== 0) begin
            errors++;
            $display("FAIL zero_ctrl clr %0d en %0d hs %0d want 1 0 0", r_clr, r_en, r_hs);
        end
    endtask

    task automatic test_backpressure();
        opa[0] = 10; opb[0] = 11; opa[1] = 12; opb[1] = 13;
        run_job(2, 0, 5, 1);
        checks++;
        if (r_timeout || r_result !== 17'd266 || r_hold_bad !== 0 || r_drop_bad !== 0) begin
            errors++;
            $display("FAIL bp_hold got %0d hold %0d drop %0d want 266 0 0",
                     r_result, r_hold_bad, r_drop_bad);
        end
        checks++;
        if (r_busy_after !== 1'b0 || r_valid_after !== 1'b0) begin
            errors++;
            $display("FAIL bp_start_ignored busy %0d valid %0d want 0 0",
                     r_busy_after, r_valid_after);
        end
        opa[0] = 1; opb[0] = 200; opa[1] = 3; opb[1] = 4;
        run_job(2, 0, 0, 0);
        checks++;
        if (r_timeout || r_result !== 17'd212 || r_lat !== 6) begin
            errors++;
            $display("FAIL bp_next_job got %0d lat %0d want 212 lat 6", r_result, r_lat);
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0, k = 0;
        for (int i = 0; i < 4; i++) begin opa[i] = 8'(i + 5); opb[i] = 8'(i + 7); end
        @(negedge clk);
        start = 1'b1; vec_len = 8'd4;
        while (idx < 1 && k < 20) begin
            @(negedge clk);
            k++;
            start = 1'b0; in_valid = 1'b1; in_a = opa[idx]; in_b = opb[idx];
            #1;
            if (in_ready && in_valid) idx++;
        end
        checks++;
        if (idx !== 1) begin
            errors++; $display("FAIL rst_mid_accept got %0d want 1", idx);
        end
        @(negedge clk);
        in_a = opa[1]; in_b = opb[1];
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, in_ready, mac_clear, mac_enable, res_valid} !== 5'b0 ||
            mac_num_1 !== '0 || mac_num_2 !== '0 || res_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got ctrl %b nums %0d/%0d res %0d want 0",
                     {busy, in_ready, mac_clear, mac_enable, res_valid},
                     mac_num_1, mac_num_2, res_data);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        opa[0] = 9; opb[0] = 9;
        run_job(1, 0, 0, 0);
        checks++;
        if (r_timeout || r_result !== 17'd81 || r_lat !== 5) begin
            errors++;
            $display("FAIL rst_mid_next got %0d lat %0d want 81 lat 5", r_result, r_lat);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            int len, gap, rdy;
            logic [ACC_W-1:0] exp;
            len = $urandom_range(0, 12);
            gap = $urandom_range(0, 2);
            rdy = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                opa[i] = 8'($urandom); opb[i] = 8'($urandom);
            end
            if (j == 0) for (int i = 0; i < len; i++) begin opa[i] = 8'hFF; opb[i] = 8'hFF; end
            exp = ref_sum(len);
            run_job(len, gap, rdy, 0);
            checks++;
            if (r_timeout || r_result !== exp) begin
                errors++;
                $display("FAIL rand%0d_result len %0d got %0d want %0d", j, len, r_result, exp);
            end
            checks++;
            if (r_lat !== ref_latency(len, gap) || r_hs !== len) begin
                errors++;
                $display("FAIL rand%0d_timing lat %0d hs %0d want %0d %0d",
                         j, r_lat, r_hs, ref_latency(len, gap), len);
            end
            checks++;
            if (r_clr !== 1 || r_en !== ((len == 0) ? 0 : r_rdy + MAC_LAT) ||
                r_zero_bad !== 0 || r_pass_bad !== 0) begin
                errors++;
                $display("FAIL rand%0d_mac_ctrl clr %0d en %0d zero %0d pass %0d",
                         j, r_clr, r_en, r_zero_bad, r_pass_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_wrap();
        test_zero_len();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
